// File: rtl/exponential_pkg_scrap.sv
// Shared bfloat16 constants, field geometry and sequencer state type for exp_sequencer.
// Special-operand helpers exist only when EXP_SEQ_SPECIAL_BYPASS_EN is defined.
package exponential_pkg_scrap;

    localparam int LAMP_FLOAT_DW   = 16;
    localparam int LAMP_FLOAT_E_DW = 8;
    localparam int LAMP_FLOAT_F_DW = 7;

    localparam logic [LAMP_FLOAT_DW-1:0] BF16_QNAN = 16'h7FC0;
    localparam logic [LAMP_FLOAT_DW-1:0] BF16_PINF = 16'h7F80;
    localparam logic [LAMP_FLOAT_DW-1:0] BF16_ZERO = 16'h0000;
    localparam logic [LAMP_FLOAT_DW-1:0] BF16_ONE  = 16'h3F80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } exp_seq_state_t;

`ifdef EXP_SEQ_SPECIAL_BYPASS_EN
    // Exponent all-ones (inf/NaN) or all-zeros (zero/flushed subnormal).
    function automatic logic bf16_is_special(input logic [LAMP_FLOAT_DW-1:0] x);
        logic [LAMP_FLOAT_E_DW-1:0] e;
        e = x[LAMP_FLOAT_DW-2 -: LAMP_FLOAT_E_DW];
        return (e == '1) || (e == '0);
    endfunction

    function automatic logic [LAMP_FLOAT_DW-1:0] bf16_special_exp(input logic [LAMP_FLOAT_DW-1:0] x);
        logic [LAMP_FLOAT_E_DW-1:0] e;
        logic [LAMP_FLOAT_F_DW-1:0] f;
        e = x[LAMP_FLOAT_DW-2 -: LAMP_FLOAT_E_DW];
        f = x[LAMP_FLOAT_F_DW-1:0];
        if (e == '0)
            return BF16_ONE;
        if (f != '0)
            return BF16_QNAN;
        if (x[LAMP_FLOAT_DW-1])
            return BF16_ZERO;
        return BF16_PINF;
    endfunction
`endif

endpackage

// File: rtl/exp_seq_fifo.sv
// Parameterized synchronous operand FIFO with combinational head; an empty FIFO presents 0.
// Storage is not reset, the head is masked while empty instead.
module exp_seq_fifo
    import exponential_pkg_scrap::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = LAMP_FLOAT_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          ready_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_i && (wptr_q == AW'(gi)))
                    mem_q[gi] <= data_i;
            end
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i)
            count_d = count_q + CW'(1);
        else if (pop_i && !push_i)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i)
                wptr_q <= wptr_q + AW'(1);
            if (pop_i)
                rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    assign empty_o = (count_q == '0);
    assign ready_o = (count_q < CW'(DEPTH));
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/exp_sequencer.sv
// Operand sequencer feeding exponential_top one operation at a time, results kept in order.
// Optional local resolution of special operands: EXP_SEQ_SPECIAL_BYPASS_EN.
module exp_sequencer
    import exponential_pkg_scrap::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    input  logic [LAMP_FLOAT_DW-1:0] in_data_i,
    output logic                     in_ready_o,
    output logic                     core_padv_o,
    output logic                     core_valid_o,
    output logic [LAMP_FLOAT_DW-1:0] core_data_o,
    input  logic                     core_ready_i,
    input  logic                     core_valid_i,
    input  logic [LAMP_FLOAT_DW-1:0] core_data_i,
    output logic                     out_valid_o,
    output logic [LAMP_FLOAT_DW-1:0] out_data_o,
    input  logic                     out_ready_i,
    output logic                     err_o
);

    exp_seq_state_t           state_q, state_d;
    logic                     out_valid_q;
    logic [LAMP_FLOAT_DW-1:0] out_data_q;
    logic                     err_q;

    logic                     push, pop, load;
    logic [LAMP_FLOAT_DW-1:0] load_data;
    logic [LAMP_FLOAT_DW-1:0] head;
    logic                     fifo_empty, fifo_ready;

    assign push = in_valid_i && fifo_ready;

    exp_seq_fifo #(
        .DEPTH (DEPTH),
        .DW    (LAMP_FLOAT_DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (in_data_i),
        .pop_i   (pop),
        .head_o  (head),
        .ready_o (fifo_ready),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        load         = 1'b0;
        load_data    = core_data_i;
        core_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Issue only into an empty output register so a load never meets a clear.
                if (!fifo_empty && !out_valid_q) begin
`ifdef EXP_SEQ_SPECIAL_BYPASS_EN
                    if (bf16_is_special(head)) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        load_data = bf16_special_exp(head);
                    end else begin
                        state_d = ST_ISSUE;
                    end
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                core_valid_o = 1'b1;
                if (core_ready_i) begin
                    pop     = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_valid_i) begin
                    load    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= load_data;
            end else if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (core_valid_i && (state_q != ST_WAIT))
                err_q <= 1'b1;
        end
    end

    assign in_ready_o  = fifo_ready;
    assign core_padv_o = rst;
    assign core_data_o = head;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_exp_sequencer.sv
// Directed bench for exp_sequencer with a 4-cycle exponential core stub (ready low while busy).
// Bypass vectors run only when EXP_SEQ_SPECIAL_BYPASS_EN is defined.
module tb_exp_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic [15:0] in_data_i;
    logic        in_ready_o;
    logic        core_padv_o;
    logic        core_valid_o;
    logic [15:0] core_data_o;
    logic        core_ready_i;
    logic        core_valid_i;
    logic [15:0] core_data_i;
    logic        out_valid_o;
    logic [15:0] out_data_o;
    logic        out_ready_i;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exp_sequencer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .core_padv_o  (core_padv_o),
        .core_valid_o (core_valid_o),
        .core_data_o  (core_data_o),
        .core_ready_i (core_ready_i),
        .core_valid_i (core_valid_i),
        .core_data_i  (core_data_i),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_ready_i  (out_ready_i),
        .err_o        (err_o)
    );

    // Core stub: accepts when idle, result visible in the 4th cycle after accept.
    logic        stub_rst;
    logic        stub_busy;
    logic [2:0]  stub_cnt;
    logic [15:0] stub_op;
    logic        inj_valid;

    function automatic logic [15:0] stub_map(input logic [15:0] x);
        case (x)
            16'hBE3A: return 16'h3F55;
            16'h3F80: return 16'h402E;
            16'h4000: return 16'h40EC;
            16'hBF80: return 16'h3EBC;
            16'h3F00: return 16'h3FD3;
            16'h4040: return 16'h41A0;
            default:  return 16'hDEAD;
        endcase
    endfunction

    always @(posedge clk) begin
        if (stub_rst) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 3'd0;
            stub_op   <= 16'h0;
        end else if (!stub_busy && core_valid_o) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 3'd1;
            stub_op   <= core_data_o;
        end else if (stub_busy) begin
            if (stub_cnt == 3'd4)
                stub_busy <= 1'b0;
            else
                stub_cnt <= stub_cnt + 3'd1;
        end
    end

    assign core_ready_i = !stub_busy;
    assign core_valid_i = (stub_busy && stub_cnt == 3'd4) || inj_valid;
    assign core_data_i  = stub_map(stub_op);

    bit mon_en  = 1'b0;
    bit cv_seen = 1'b0;
    always @(negedge clk) if (mon_en && core_valid_o) cv_seen = 1'b1;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end else begin
            $display("ok   %s value=%h", tag, act);
        end
    endtask

    // Returns at the first negedge (including the current one) with out_valid_o high.
    task automatic wait_out(input int max_cycles, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (out_valid_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    logic [15:0] ops  [5];
    logic [15:0] exps [5];

    initial begin
        bit got;
        bit issued;
        int n;

        ops  = '{16'h3F80, 16'h4000, 16'hBF80, 16'h3F00, 16'h4040};
        exps = '{16'h402E, 16'h40EC, 16'h3EBC, 16'h3FD3, 16'h41A0};

        rst = 1'b1; stub_rst = 1'b1; inj_valid = 1'b0;
        in_valid_i = 1'b0; in_data_i = 16'h0; out_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready_o, 1'b1);
        check_eq("rst_core_valid", core_valid_o, 1'b0);
        check_eq("rst_core_data", core_data_o, 16'h0);
        check_eq("rst_out_valid", out_valid_o, 1'b0);
        check_eq("rst_out_data", out_data_o, 16'h0);
        check_eq("rst_err", err_o, 1'b0);
        check_eq("rst_padv", core_padv_o, 1'b1);
        rst = 1'b0; stub_rst = 1'b0;
        @(negedge clk);
        check_eq("run_padv", core_padv_o, 1'b0);

        // Single operation: push at edge N.
        in_valid_i = 1'b1; in_data_i = 16'hBE3A;
        @(negedge clk);
        in_valid_i = 1'b0;
        check_eq("t1_cv_N", core_valid_o, 1'b0);
        check_eq("t1_head", core_data_o, 16'hBE3A);
        @(negedge clk);
        check_eq("t1_cv_N1", core_valid_o, 1'b1);
        @(negedge clk);
        check_eq("t1_cv_N2", core_valid_o, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("t1_ov_N5", out_valid_o, 1'b0);
        @(negedge clk);
        check_eq("t1_ov_N6", out_valid_o, 1'b1);
        check_eq("t1_data", out_data_o, 16'h3F55);

        // Fill while the first result is held.
        for (int i = 0; i < DEPTH; i++) begin
            in_valid_i = 1'b1; in_data_i = ops[i];
            @(negedge clk);
        end
        check_eq("t2_full_ready", in_ready_o, 1'b0);
        in_data_i = ops[4];
        issued = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (core_valid_o) issued = 1'b1;
        end
        check_eq("t3_no_issue", issued, 1'b0);
        check_eq("t3_hold_valid", out_valid_o, 1'b1);
        check_eq("t3_hold_data", out_data_o, 16'h3F55);
        check_eq("t2_still_full", in_ready_o, 1'b0);
        check_eq("t2_head", core_data_o, ops[0]);

        out_ready_i = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (in_ready_o) break;
        end
        check_eq("t2_ready_after_pop", 16'(n), 16'd3);
        @(negedge clk);
        in_valid_i = 1'b0;

        for (int i = 0; i < 5; i++) begin
            wait_out(40, got);
            check_eq($sformatf("t3_res%0d_seen", i), got, 1'b1);
            check_eq($sformatf("t3_res%0d_data", i), out_data_o, exps[i]);
            @(negedge clk);
        end

        // Spurious core result while idle.
        repeat (2) @(negedge clk);
        check_eq("t4_err_before", err_o, 1'b0);
        inj_valid = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
        check_eq("t4_err_set", err_o, 1'b1);
        check_eq("t4_out_valid", out_valid_o, 1'b0);
        check_eq("t4_core_valid", core_valid_o, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("t4_err_sticky", err_o, 1'b1);

        // Reset while waiting on the core.
        in_valid_i = 1'b1; in_data_i = 16'h3F80;
        @(negedge clk);
        in_valid_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (core_valid_o) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("t5_issue_seen", got, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_padv", core_padv_o, 1'b1);
        check_eq("t5_in_ready", in_ready_o, 1'b1);
        check_eq("t5_core_valid", core_valid_o, 1'b0);
        check_eq("t5_core_data", core_data_o, 16'h0);
        check_eq("t5_out_valid", out_valid_o, 1'b0);
        check_eq("t5_err", err_o, 1'b0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t5_late_err", err_o, 1'b1);
        check_eq("t5_late_out_valid", out_valid_o, 1'b0);
        check_eq("t5_late_out_data", out_data_o, 16'h0);

`ifdef EXP_SEQ_SPECIAL_BYPASS_EN
        begin
            logic [15:0] sp_in  [4];
            logic [15:0] sp_exp [4];
            sp_in  = '{16'h7F80, 16'hFF80, 16'h0000, 16'h7FC1};
            sp_exp = '{16'h7F80, 16'h0000, 16'h3F80, 16'h7FC0};
            mon_en = 1'b1;
            out_ready_i = 1'b0;
            for (int i = 0; i < 4; i++) begin
                in_valid_i = 1'b1; in_data_i = sp_in[i];
                @(negedge clk);
            end
            in_valid_i = 1'b0;
            out_ready_i = 1'b1;
            for (int i = 0; i < 4; i++) begin
                wait_out(20, got);
                check_eq($sformatf("byp%0d_seen", i), got, 1'b1);
                check_eq($sformatf("byp%0d_data", i), out_data_o, sp_exp[i]);
                @(negedge clk);
            end
            repeat (3) @(negedge clk);
            mon_en = 1'b0;
            check_eq("byp_no_core_valid", cv_seen, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exp_sequencer.md
# exp_sequencer

Operand sequencer placed directly upstream of `exponential_top`. It buffers incoming bfloat16 operands in a FIFO, issues them one at a time to the exponential core over its `valid_i`/`ready_o` handshake, and captures each `data_o`/`valid_o` result. It presents results in order to the consumer through a valid/ready output register. It also drives the core's `padv_i` during reset.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid_i`  in  1  operand offered
- `in_data_i`  in  LAMP_FLOAT_DW  bfloat16 operand
- `in_ready_o`  out  1  FIFO can accept
- `core_padv_o`  out  1  to core `padv_i`
- `core_valid_o`  out  1  to core `valid_i`
- `core_data_o`  out  LAMP_FLOAT_DW  to core `data_i`
- `core_ready_i`  in  1  from core `ready_o`
- `core_valid_i`  in  1  from core `valid_o`
- `core_data_i`  in  LAMP_FLOAT_DW  from core `data_o`
- `out_valid_o`  out  1  result held
- `out_data_o`  out  LAMP_FLOAT_DW  result e^x
- `out_ready_i`  in  1  consumer accepts
- `err_o`  out  1  sticky: `core_valid_i` while not in WAIT

## Operation
- FIFO: `in_ready_o = (count < DEPTH)`. A push occurs when `in_valid_i && in_ready_o`. When full, `in_ready_o` is 0 even if a pop happens in the same cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` is log2(DEPTH)+1 bits. `core_data_o` is always the FIFO head.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when `count>0 && !out_valid_o`.
  - ISSUE: `core_valid_o=1`. When `core_ready_i=1`, pop the head and go to WAIT; otherwise stay in ISSUE.
  - WAIT: on `core_valid_i`, load `out_data_o` from `core_data_i`, set `out_valid_o`, and go to IDLE.
- At most one operation is in flight at a time, so results come out in order.
- The output register clears on `out_valid_o && out_ready_i`. A clear and a new load cannot coincide, because issue requires the output register to be empty.
- `core_valid_i` in IDLE or ISSUE is ignored and sets `err_o`. `err_o` clears only on reset.
- `core_padv_o = rst`, which flushes the core while reset is asserted.

## Timing
- Reset values: `in_ready_o=1`, `core_valid_o=0`, `core_data_o=0` (empty FIFO reads 0), `out_valid_o=0`, `out_data_o=0`, `err_o=0`, FSM in IDLE, count 0.
- Reset asserted mid-operation drops all buffered and in-flight data. Any result the core returns afterwards is ignored.
- Push at edge N → state ISSUE at edge N+1 → `core_valid_o` high in cycle N+1.
- Pop at the first edge with `core_ready_i`.
- Result captured at the edge where `core_valid_i` is seen in WAIT; `out_valid_o` is high from the next cycle.
- Best-case latency from push to `out_valid_o` is 2 + core latency cycles.
- `core_valid_o` is high for exactly one accepted cycle per operand.

## Configuration
- `EXP_SEQ_SPECIAL_BYPASS_EN` defined: in IDLE with `!out_valid_o`, a special head operand is popped and resolved locally in one cycle, and the core is not used.
  - NaN → 0x7FC0
  - +inf → 0x7F80
  - −inf → 0x0000
  - ±0 (including subnormals flushed) → 0x3F80
  - Ordering is preserved, because no operation is in flight while in IDLE.
- Undefined: every operand goes to the core. No classifier logic is present.

## Structure
- `exponential_pkg_scrap` holds:
  - `LAMP_FLOAT_DW`
  - the bfloat16 field widths
  - the special constants (`BF16_QNAN`, `BF16_PINF`, `BF16_ZERO`, `BF16_ONE`)
  - the `exp_seq_state_t` enum
- One sub-module, `exp_seq_fifo`, implements the parameterized synchronous FIFO with push/pop/count. The FSM and output register stay in the top module.

## Test plan
The bench uses a core stub with 4-cycle latency and `ready_o` low while busy.
- Push 0xBE3A, stub returns 0x3F55 → `core_valid_o` high in cycle N+1; `out_data_o=0x3F55`, `out_valid_o` high 6 cycles after the push; one operation only.
- Push DEPTH+1 operands back-to-back with `out_ready_i=0` → `in_ready_o` falls after DEPTH pushes. The extra operand is not accepted until the first pop.
- Hold `out_ready_i=0` for 10 cycles after the first result → no second issue; resume → results 2..4 arrive in push order.
- Pulse `core_valid_i` while in IDLE → `err_o=1`, sticky; outputs unchanged.
- Assert `rst` while in WAIT → all outputs return to reset values and `core_padv_o=1`. A stub result after reset is dropped and `err_o` is set.
- With `EXP_SEQ_SPECIAL_BYPASS_EN`, push 0x7F80, 0xFF80, 0x0000, 0x7FC1 → outputs 0x7F80, 0x0000, 0x3F80, 0x7FC0, with `core_valid_o` never asserted.
